// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU opcodes, requester id type and result reset values
// shared by the alu, the arbiter front end and the benches.
package alu_arbiter_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam int REQ_IDW = 1;
   typedef logic [REQ_IDW-1:0] req_id_t;

   localparam logic [31:0] RES_RST  = 32'd0;
   localparam logic        ZERO_RST = 1'b0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  s;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; shifts use the separate 5-bit amount i_s
// rather than srcB, SLT is a signed compare.
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [31:0] i_srcA,
   input  logic [31:0] i_srcB,
   input  logic [2:0]  i_ALUop,
   input  logic [4:0]  i_s,
   output logic [31:0] o_ALUout,
   output logic        o_zero
);

   always_comb begin
      o_ALUout = '0;
      unique case (i_ALUop)
         ALU_ADD: o_ALUout = i_srcA + i_srcB;
         ALU_SUB: o_ALUout = i_srcA - i_srcB;
         ALU_AND: o_ALUout = i_srcA & i_srcB;
         ALU_OR:  o_ALUout = i_srcA | i_srcB;
         ALU_XOR: o_ALUout = i_srcA ^ i_srcB;
         ALU_SLL: o_ALUout = i_srcA << i_s;
         ALU_SRL: o_ALUout = i_srcA >> i_s;
         ALU_SLT: o_ALUout = {31'd0, $signed(i_srcA) < $signed(i_srcB)};
      endcase
   end

   assign o_zero = (o_ALUout == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one alu between two requesters,
// with a registered operand stage and a one-entry response slot each.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req_valid,
   output logic        r0_req_ready,
   input  logic [31:0] r0_srcA,
   input  logic [31:0] r0_srcB,
   input  logic [2:0]  r0_ALUop,
   input  logic [4:0]  r0_s,
   output logic        r0_resp_valid,
   input  logic        r0_resp_ready,
   output logic [31:0] r0_ALUout,
   output logic        r0_zero,
   input  logic        r1_req_valid,
   output logic        r1_req_ready,
   input  logic [31:0] r1_srcA,
   input  logic [31:0] r1_srcB,
   input  logic [2:0]  r1_ALUop,
   input  logic [4:0]  r1_s,
   output logic        r1_resp_valid,
   input  logic        r1_resp_ready,
   output logic [31:0] r1_ALUout,
   output logic        r1_zero
);

   logic [NREQ-1:0] w_req_valid;
   logic [NREQ-1:0] w_req_ready;
   logic [NREQ-1:0] w_resp_ready;
   alu_req_t        w_req [NREQ];
   alu_req_t        r_s1;
   logic            r_s1_valid;
   req_id_t         r_s1_tag;
   req_id_t         r_rr_ptr;
   req_id_t         w_gnt;
   logic            w_s1_adv;
   logic            w_s1_free;
   logic            w_acc;
   logic [NREQ-1:0] r_slot_v;
   logic [NREQ-1:0] r_slot_z;
   logic [31:0]     r_slot_out [NREQ];
   logic [31:0]     w_alu_out;
   logic            w_alu_zero;

   assign w_req_valid  = {r1_req_valid, r0_req_valid};
   assign w_resp_ready = {r1_resp_ready, r0_resp_ready};
   assign w_req[0]     = {r0_srcA, r0_srcB, r0_ALUop, r0_s};
   assign w_req[1]     = {r1_srcA, r1_srcB, r1_ALUop, r1_s};

   assign w_s1_adv  = r_s1_valid &&
                      (!r_slot_v[r_s1_tag] || w_resp_ready[r_s1_tag]);
   assign w_s1_free = !r_s1_valid || w_s1_adv;

   // Preferred requester wins; the other only when preferred is idle.
   always_comb begin
      w_gnt = r_rr_ptr;
      if (!w_req_valid[r_rr_ptr] && w_req_valid[~r_rr_ptr])
         w_gnt = ~r_rr_ptr;
   end

   assign w_acc          = w_s1_free && w_req_valid[w_gnt];
   assign w_req_ready[0] = w_s1_free && (w_gnt == req_id_t'(0));
   assign w_req_ready[1] = w_s1_free && (w_gnt == req_id_t'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_tag   <= '0;
         r_s1       <= '0;
         r_rr_ptr   <= '0;
      end else if (w_acc) begin
         r_s1_valid <= 1'b1;
         r_s1_tag   <= w_gnt;
         r_s1       <= w_req[w_gnt];
         r_rr_ptr   <= ~w_gnt;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   alu u_alu (
      .i_srcA   (r_s1.a),
      .i_srcB   (r_s1.b),
      .i_ALUop  (r_s1.op),
      .i_s      (r_s1.s),
      .o_ALUout (w_alu_out),
      .o_zero   (w_alu_zero)
   );

   // A fill on the same edge as a drain keeps the slot valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot_v <= '0;
         r_slot_z <= {NREQ{ZERO_RST}};
         for (int k = 0; k < NREQ; k++)
            r_slot_out[k] <= RES_RST;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (w_s1_adv && r_s1_tag == req_id_t'(k)) begin
               r_slot_v[k]   <= 1'b1;
               r_slot_out[k] <= w_alu_out;
               r_slot_z[k]   <= w_alu_zero;
            end else if (w_resp_ready[k]) begin
               r_slot_v[k] <= 1'b0;
            end
         end
      end
   end

   assign r0_req_ready  = w_req_ready[0];
   assign r1_req_ready  = w_req_ready[1];
   assign r0_resp_valid = r_slot_v[0];
   assign r1_resp_valid = r_slot_v[1];
   assign r0_ALUout     = r_slot_out[0];
   assign r1_ALUout     = r_slot_out[1];
   assign r0_zero       = r_slot_z[0];
   assign r1_zero       = r_slot_z[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of the two-requester ALU
// front end against per-requester queues of expected results.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   typedef logic [32:0] res_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       resp_ready;
   logic [1:0][31:0] srcA;
   logic [1:0][31:0] srcB;
   logic [1:0][2:0]  op;
   logic [1:0][4:0]  sh;
   wire  [1:0]       req_ready;
   wire  [1:0]       resp_valid;
   wire  [1:0]       zero;
   wire  [1:0][31:0] alu_out;

   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   res_t expq [2][$];
   int   waitc [2];

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_req_valid  (req_valid[0]),
      .r0_req_ready  (req_ready[0]),
      .r0_srcA       (srcA[0]),
      .r0_srcB       (srcB[0]),
      .r0_ALUop      (op[0]),
      .r0_s          (sh[0]),
      .r0_resp_valid (resp_valid[0]),
      .r0_resp_ready (resp_ready[0]),
      .r0_ALUout     (alu_out[0]),
      .r0_zero       (zero[0]),
      .r1_req_valid  (req_valid[1]),
      .r1_req_ready  (req_ready[1]),
      .r1_srcA       (srcA[1]),
      .r1_srcB       (srcB[1]),
      .r1_ALUop      (op[1]),
      .r1_s          (sh[1]),
      .r1_resp_valid (resp_valid[1]),
      .r1_resp_ready (resp_ready[1]),
      .r1_ALUout     (alu_out[1]),
      .r1_zero       (zero[1])
   );

   function automatic res_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] o, input logic [4:0] s);
      logic [31:0] r;
      case (o)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLL: r = a << s;
         ALU_SRL: r = a >> s;
         default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   // Scoreboard: every visible response must be the oldest outstanding
   // result of its requester; resets discard everything in flight.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            expq[k].delete();
            waitc[k] = 0;
         end
      end else if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            if (resp_valid[k]) begin
               total++;
               if (expq[k].size() == 0) begin
                  bad++;
                  $display("FAIL stale_resp r%0d: got out=%h with nothing outstanding",
                           k, alu_out[k]);
               end else begin
                  if ({zero[k], alu_out[k]} !== expq[k][0]) begin
                     bad++;
                     $display("FAIL resp_data r%0d: got zero=%b out=%h required zero=%b out=%h",
                              k, zero[k], alu_out[k], expq[k][0][32], expq[k][0][31:0]);
                  end
                  if (resp_ready[k]) void'(expq[k].pop_front());
               end
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               expq[k].push_back(ref_op(srcA[k], srcB[k], op[k], sh[k]));
               waitc[k] = 0;
            end else if (req_valid[k] && req_valid[1-k] && req_ready[1-k]) begin
               waitc[k]++;
               total++;
               if (waitc[k] > 1) begin
                  bad++;
                  $display("FAIL fairness r%0d: waited behind %0d accepts, required at most 1",
                           k, waitc[k]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s);
      op[k]   = o;
      srcA[k] = a;
      srcB[k] = b;
      sh[k]   = s;
   endtask

   task automatic rand_req(input int k);
      logic [31:0] a;
      a = $urandom();
      set_req(k, 3'($urandom_range(0, 7)), a,
              ($urandom_range(0, 3) == 0) ? a : $urandom(),
              5'($urandom_range(0, 31)));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      srcA = '0; srcB = '0; op = '0; sh = '0;
      #2;
      total++;
      if (resp_valid !== 2'b00) begin
         bad++;
         $display("FAIL reset_resp_valid: got %b required 00", resp_valid);
      end
      total++;
      if (alu_out[0] !== RES_RST || alu_out[1] !== RES_RST) begin
         bad++;
         $display("FAIL reset_aluout: got %h/%h required 0", alu_out[0], alu_out[1]);
      end
      total++;
      if (zero !== 2'b00) begin
         bad++;
         $display("FAIL reset_zero: got %b required 00", zero);
      end
      req_valid = 2'b01;
      #1;
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL reset_ready_r0: got %b required 01", req_ready);
      end
      req_valid = 2'b10;
      #1;
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL reset_ready_r1: got %b required 10", req_ready);
      end
      req_valid = 2'b00;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      tick();
      resp_ready = 2'b11;
      set_req(0, ALU_ADD, 32'd200, 32'd200, 5'd0);
      req_valid[0] = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL single_ready: got %b required 1", req_ready[0]);
      end
      tick();
      req_valid[0] = 1'b0;
      total++;
      if (resp_valid[0] !== 1'b0) begin
         bad++;
         $display("FAIL single_early: got resp_valid %b required 0", resp_valid[0]);
      end
      tick();
      total++;
      if (resp_valid !== 2'b01 || alu_out[0] !== 32'd400 || zero[0] !== 1'b0) begin
         bad++;
         $display("FAIL single_result: got valid=%b out=%0d zero=%b required 01/400/0",
                  resp_valid, alu_out[0], zero[0]);
      end
      tick();
   endtask

   task automatic test_zero();
      set_req(1, ALU_SUB, 32'd200, 32'd200, 5'd0);
      req_valid[1] = 1'b1;
      tick();
      req_valid[1] = 1'b0;
      tick();
      total++;
      if (resp_valid !== 2'b10 || alu_out[1] !== 32'd0 || zero[1] !== 1'b1) begin
         bad++;
         $display("FAIL zero_flag: got valid=%b out=%0d zero=%b required 10/0/1",
                  resp_valid, alu_out[1], zero[1]);
      end
      tick();
   endtask

   task automatic test_contention();
      int n [2];
      int acc;
      int cyc;
      int exp_k;
      logic [1:0] hs;
      rst_n = 1'b0;
      resp_ready = 2'b11;
      rand_req(0);
      rand_req(1);
      req_valid = 2'b11;
      n[0] = 0; n[1] = 0;
      acc = 0; cyc = 0; exp_k = 0;
      tick();
      rst_n = 1'b1;
      while (acc < 8 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         hs = req_valid & req_ready;
         if (hs != 2'b00) begin
            total++;
            if (hs !== (2'b01 << exp_k)) begin
               bad++;
               $display("FAIL grant_order: accept %0d got %b required r%0d", acc, hs, exp_k);
            end
            acc++;
            exp_k ^= 1;
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            if (hs[k]) begin
               n[k]++;
               if (n[k] < 4) rand_req(k);
               else req_valid[k] = 1'b0;
            end
         end
      end
      total++;
      if (cyc !== 8 || acc !== 8) begin
         bad++;
         $display("FAIL contention_rate: got %0d accepts in %0d cycles required 8 in 8",
                  acc, cyc);
      end
      repeat (3) tick();
   endtask

   task automatic test_backpressure();
      res_t e1, e2;
      resp_ready = 2'b00;
      set_req(0, ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0);
      e1 = ref_op(32'h1234_5678, 32'h0F0F_0F0F, ALU_XOR, 5'd0);
      req_valid = 2'b01;
      tick();
      set_req(0, ALU_SLL, 32'h0000_00F1, 32'd0, 5'd8);
      e2 = ref_op(32'h0000_00F1, 32'd0, ALU_SLL, 5'd8);
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL bp_second_accept: got ready %b required 1", req_ready[0]);
      end
      tick();
      req_valid[0] = 1'b0;
      set_req(1, ALU_OR, 32'h00FF_0000, 32'h0000_00FF, 5'd0);
      req_valid[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (req_ready !== 2'b00 || resp_valid[0] !== 1'b1 || alu_out[0] !== e1[31:0]) begin
            bad++;
            $display("FAIL bp_stall: got ready=%b valid=%b out=%h required 00/1/%h",
                     req_ready, resp_valid[0], alu_out[0], e1[31:0]);
         end
         tick();
      end
      resp_ready = 2'b11;
      tick();
      req_valid[1] = 1'b0;
      total++;
      if (resp_valid[0] !== 1'b1 || alu_out[0] !== e2[31:0]) begin
         bad++;
         $display("FAIL bp_drain_second: got valid=%b out=%h required 1/%h",
                  resp_valid[0], alu_out[0], e2[31:0]);
      end
      tick();
      total++;
      if (resp_valid !== 2'b10) begin
         bad++;
         $display("FAIL bp_after_drain: got valid=%b required 10", resp_valid);
      end
      repeat (2) tick();
   endtask

   task automatic test_fill_drain();
      res_t e1, e2;
      resp_ready = 2'b11;
      set_req(0, ALU_SLT, 32'hFFFF_FFF0, 32'd5, 5'd0);
      e1 = ref_op(32'hFFFF_FFF0, 32'd5, ALU_SLT, 5'd0);
      req_valid = 2'b01;
      tick();
      set_req(0, ALU_SRL, 32'h8000_0000, 32'd0, 5'd31);
      e2 = ref_op(32'h8000_0000, 32'd0, ALU_SRL, 5'd31);
      tick();
      req_valid = 2'b00;
      total++;
      if (resp_valid[0] !== 1'b1 || alu_out[0] !== e1[31:0]) begin
         bad++;
         $display("FAIL fd_first: got valid=%b out=%h required 1/%h",
                  resp_valid[0], alu_out[0], e1[31:0]);
      end
      tick();
      total++;
      if (resp_valid[0] !== 1'b1 || alu_out[0] !== e2[31:0]) begin
         bad++;
         $display("FAIL fd_same_edge: got valid=%b out=%h required 1/%h",
                  resp_valid[0], alu_out[0], e2[31:0]);
      end
      tick();
      total++;
      if (resp_valid[0] !== 1'b0) begin
         bad++;
         $display("FAIL fd_empty: got valid=%b required 0", resp_valid[0]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [1:0] hs;
      resp_ready = 2'b00;
      rand_req(0);
      rand_req(1);
      req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         tick();
         for (int k = 0; k < 2; k++) if (hs[k]) rand_req(k);
      end
      @(negedge clk);
      total++;
      if (resp_valid !== 2'b11) begin
         bad++;
         $display("FAIL rm_setup: got valid=%b required 11", resp_valid);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (resp_valid !== 2'b00 || alu_out[0] !== 32'd0 || alu_out[1] !== 32'd0
          || zero !== 2'b00) begin
         bad++;
         $display("FAIL rm_async: got valid=%b out=%h/%h zero=%b required 00/0/0/00",
                  resp_valid, alu_out[0], alu_out[1], zero);
      end
      set_req(0, ALU_ADD, 32'd7, 32'd9, 5'd0);
      set_req(1, ALU_AND, 32'hF0F0, 32'hFF00, 5'd0);
      resp_ready = 2'b11;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ((req_valid & req_ready) !== 2'b01) begin
         bad++;
         $display("FAIL rm_first_grant: got %b required 01", req_valid & req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      tick();
      req_valid[1] = 1'b0;
      repeat (3) tick();
      total++;
      if (expq[0].size() != 0 || expq[1].size() != 0) begin
         bad++;
         $display("FAIL rm_lost: got %0d/%0d outstanding required 0/0",
                  expq[0].size(), expq[1].size());
      end
   endtask

   task automatic test_random();
      logic [1:0] hs;
      hs = 2'b00;
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (hs[k] || !req_valid[k]) begin
               req_valid[k] = ($urandom_range(0, 3) != 0);
               rand_req(k);
            end
            resp_ready[k] = ($urandom_range(0, 4) != 0);
         end
         @(negedge clk);
         hs = req_valid & req_ready;
      end
      tick();
      req_valid = 2'b00;
      resp_ready = 2'b11;
      repeat (4) tick();
      total++;
      if (expq[0].size() != 0 || expq[1].size() != 0) begin
         bad++;
         $display("FAIL random_lost: got %0d/%0d outstanding required 0/0",
                  expq[0].size(), expq[1].size());
      end
   endtask

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_single();
      test_zero();
      test_contention();
      test_backpressure();
      test_fill_drain();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin front end for the shared 32-bit `alu`. Sits between two issuing clients (e.g. the execute stage and a multi-cycle helper unit) and one `alu` instance. Accepts at most one operation per cycle through valid/ready handshakes and pipelines it through a registered operand stage. Returns each result, with its `zero` flag, to the requester that issued it through a one-entry per-requester response slot.

## Interface
- `NREQ`, 2: number of requesters. Fixed; only 2 is supported.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `r0_req_valid`, `r1_req_valid` in 1: request present.
- `r0_req_ready`, `r1_req_ready` out 1: request accepted this cycle when `valid && ready`.
- `r0_srcA`, `r1_srcA` in 32: operand A.
- `r0_srcB`, `r1_srcB` in 32: operand B.
- `r0_ALUop`, `r1_ALUop` in 3: ALU operation. Encoding per package constants.
- `r0_s`, `r1_s` in 5: shift amount.
- `r0_resp_valid`, `r1_resp_valid` out 1: result held in the slot.
- `r0_resp_ready`, `r1_resp_ready` in 1: requester consumes the result when `valid && ready`.
- `r0_ALUout`, `r1_ALUout` out 32: result.
- `r0_zero`, `r1_zero` out 1: `zero` flag from the ALU.

## Operation
- **Stage 1 (operand register):**
  - Contents: `s1_valid`, `s1_tag` (requester id), `srcA`, `srcB`, `ALUop`, `s`.
  - Drives the `alu` directly.
- **Stage 2 (response slots):** one per requester. Contents: `valid`, `ALUout`, `zero`.
- **Advance condition:**
  - `s1_adv = s1_valid && (!slot[s1_tag].valid || rK_resp_ready)`, where K = `s1_tag`.
  - On `s1_adv`, the slot is loaded from the ALU outputs.
- **Accept condition:** `s1_free = !s1_valid || s1_adv`.
- **Arbitration:**
  - `rr_ptr` (1 bit) names the preferred requester.
  - Grant goes to the preferred requester if it is valid, else to the other one.
  - `rK_req_ready = s1_free && grant==K`. This may depend combinationally on both `req_valid` inputs.
  - No requester waits more than one accepted transaction behind the other.
- **Pointer update:** after an accepted handshake from requester K, `rr_ptr <= ~K`. Otherwise `rr_ptr` holds.
- **Slot update:**
  - A slot clears on its `resp_valid && resp_ready`.
  - Same-edge fill and drain of one slot: fill wins, and `valid` stays 1.
- **Ordering:** results return in issue order per requester. There is no cross-requester ordering guarantee.
- **Backpressure:**
  - A full, undrained slot for `s1_tag` stalls stage 1.
  - A stalled stage 1 deasserts both `req_ready` outputs, including the requester whose slot is free (head-of-line blocking is accepted).
- **Reset (`rst_n` low, asynchronous):**
  - Outputs: all `resp_valid` = 0, all `ALUout` = 0, all `zero` = 0.
  - Internal state: `s1_valid` = 0, `rr_ptr` = 0.
  - `req_ready` outputs: reflect `s1_free` = 1 combinationally.
  - In-flight operations are discarded and never returned.

## Timing
- Handshake at edge N: operands are registered into stage 1.
- If the slot is free, `resp_valid` is high after edge N+1, i.e. one cycle later.
- Throughput: one operation per cycle sustained when responses are drained every cycle.
- The ALU is combinational from the stage-1 registers. The ALU path is register-to-register within one cycle.
- `resp_*` outputs are registered. `req_ready` is combinational from state and `req_valid`.
- Both requesters valid on the first cycle after reset: requester 0 is granted, then requester 1 on the next cycle.
- Stall: stage 1 holds its contents unchanged until its target slot drains. The ALU inputs stay stable during the stall.

## Structure
- Shared package holds:
  - The 3-bit ALU op constants (`ALU_ADD`, `ALU_SUB`, `ALU_OR`, …), shared with `alu` and the benches.
  - Requester id width.
  - The reset values for the result fields.
- Exactly one sub-module: the existing `alu`, instantiated once and unchanged.
- Arbitration and slots are inline. No separate arbiter module.

## Test plan
- **Single request:** r0 issues `ALU_ADD` 200,200 with `r0_resp_ready`=1 → `r0_resp_valid` one cycle after the handshake, `r0_ALUout`=400, `r0_zero`=0. r1 sees no response.
- **Zero flag:** r1 issues `ALU_SUB` 200,200 → `r1_ALUout`=0, `r1_zero`=1.
- **Contention:** both valid continuously from reset, each with 4 ops.
  - Grants alternate r0,r1,r0,r1,…
  - 8 accepts in 8 cycles.
  - Each requester's results arrive in its own issue order.
- **Backpressure:**
  - Setup: `r0_resp_ready`=0, r0 issues 2 ops.
  - The first op fills the slot. The second stalls in stage 1, and both `req_ready` are 0 while stalled.
  - Raising `r0_resp_ready` drains both ops on consecutive cycles, with no loss or duplication.
- **Fill/drain same edge:** slot 0 full with `r0_resp_ready`=1 while stage 1 holds a second r0 op → `r0_resp_valid` stays 1 and shows the new value one cycle later.
- **Reset mid-operation:** assert `rst_n`=0 with stage 1 and both slots valid.
  - Immediately: `resp_valid`=0 and `ALUout`=0, asynchronously.
  - After release: the first grant goes to r0, and no stale results appear.
